// File: rtl/cond_unit.sv
// Execute-stage condition/flag unit: NZCV register, ARM condition evaluation, gated write enables.
// Optional saturating squash counter enabled by defining COND_SQUASH_CNT_EN.
module cond_unit #(
  parameter logic [3:0]  FLAG_RST = 4'b0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  input  logic [3:0]       cond,
  input  logic             s_bit,
  input  logic [1:0]       alu_op,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             reg_write_in,
  input  logic             mem_write_in,
  input  logic             pc_src_in,
  input  logic             stall,
  input  logic             flush,
  output logic             valid_out,
  output logic             cond_ex_out,
  output logic             reg_write,
  output logic             mem_write,
  output logic             pc_src,
`ifdef COND_SQUASH_CNT_EN
  output logic [CNT_W-1:0] squash_cnt,
`endif
  output logic [3:0]       flags
);

  logic cond_ex;
  logic adv;
  logic upd;
  logic fn, fz, fc, fv;

  assign {fn, fz, fc, fv} = flags;

  // Evaluated on the flags held before this instruction's own update.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = fz;
      4'b0001: cond_ex = ~fz;
      4'b0010: cond_ex = fc;
      4'b0011: cond_ex = ~fc;
      4'b0100: cond_ex = fn;
      4'b0101: cond_ex = ~fn;
      4'b0110: cond_ex = fv;
      4'b0111: cond_ex = ~fv;
      4'b1000: cond_ex = fc & ~fz;
      4'b1001: cond_ex = ~fc | fz;
      4'b1010: cond_ex = (fn == fv);
      4'b1011: cond_ex = (fn != fv);
      4'b1100: cond_ex = ~fz & (fn == fv);
      4'b1101: cond_ex = fz | (fn != fv);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign adv = valid_in & ~stall & ~flush;
  assign upd = adv & s_bit & cond_ex;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags       <= FLAG_RST;
      valid_out   <= 1'b0;
      cond_ex_out <= 1'b0;
      reg_write   <= 1'b0;
      mem_write   <= 1'b0;
      pc_src      <= 1'b0;
    end else begin
      if (upd) begin
        flags[3] <= alu_n;
        flags[2] <= alu_z;
        // Logical ops leave carry and overflow untouched.
        if (!alu_op[1]) begin
          flags[1] <= alu_c;
          flags[0] <= alu_v;
        end
      end
      if (flush) begin
        valid_out   <= 1'b0;
        cond_ex_out <= 1'b0;
        reg_write   <= 1'b0;
        mem_write   <= 1'b0;
        pc_src      <= 1'b0;
      end else if (!stall) begin
        valid_out   <= valid_in;
        cond_ex_out <= valid_in & cond_ex;
        reg_write   <= valid_in & cond_ex & reg_write_in;
        mem_write   <= valid_in & cond_ex & mem_write_in;
        pc_src      <= valid_in & cond_ex & pc_src_in;
      end
    end
  end

`ifdef COND_SQUASH_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      squash_cnt <= '0;
    end else if (adv && !cond_ex && (squash_cnt != '1)) begin
      squash_cnt <= squash_cnt + 1'b1;
    end
  end
`endif

endmodule
